// File: rtl/vga_wb_regs_ng.sv
// ---------------------------------------------------------------------------
// vga_wb_regs_ng
// Wishbone register / CLUT-access slave for the VGA/LCD controller.
// Holds CTRL, STAT, HTIM, VTIM, HVLEN, IEN and a ring of NUM_VBAR video base
// address registers, rotates the video bank on vbs_done, and forwards CLUT
// accesses (ADR_I[9] set) through a request/ack handshake with a timeout.
//
// Ports
//   CLK_I, nRESET (async, active low), RST_I (sync, active high)
//   ADR_I[9:0]   word address [11:2]; ADR_I[9] selects CLUT space
//   DAT_I/DAT_O  write / registered read data
//   SEL_I, WE_I, STB_I, CYC_I, ACK_O, ERR_O   Wishbone slave signals
//   INTA_O       registered interrupt request
//   int_in       interrupt event pulses
//   vbs_done     video bank switch done pulse
//   acmp         active CLUT page
//   ctrl_o, htim_o, vtim_o, hvlen_o   register contents
//   vbar_cur, vbar_nxt   current / next bank base address [31:2]
//   clut_acc, clut_ack, clut_q        CLUT access handshake
//
// Bus FSM
//   state     | meaning
//   IDLE      | waiting for CYC_I & STB_I
//   CLUT_WAIT | clut_acc raised, waiting for clut_ack or timeout
//   RESP      | ACK_O or ERR_O high for this single cycle
// ---------------------------------------------------------------------------
module vga_wb_regs_ng #(
    parameter int NUM_VBAR = 2,
    parameter int NUM_INT  = 6,
    parameter int CLUT_TO  = 15
) (
    input  logic               CLK_I,
    input  logic               nRESET,
    input  logic               RST_I,
    input  logic [9:0]         ADR_I,
    input  logic [31:0]        DAT_I,
    output logic [31:0]        DAT_O,
    input  logic [3:0]         SEL_I,
    input  logic               WE_I,
    input  logic               STB_I,
    input  logic               CYC_I,
    output logic               ACK_O,
    output logic               ERR_O,
    output logic               INTA_O,
    input  logic [NUM_INT-1:0] int_in,
    input  logic               vbs_done,
    input  logic               acmp,
    output logic [11:0]        ctrl_o,
    output logic [31:0]        htim_o,
    output logic [31:0]        vtim_o,
    output logic [31:0]        hvlen_o,
    output logic [29:0]        vbar_cur,
    output logic [29:0]        vbar_nxt,
    output logic               clut_acc,
    input  logic               clut_ack,
    input  logic [23:0]        clut_q
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLUT_WAIT = 2'd1,
        RESP      = 2'd2
    } bus_state_t;

    localparam logic [2:0] LAST_MAX = 3'(NUM_VBAR - 1);
    localparam logic [7:0] TO_LAST  = 8'(CLUT_TO - 1);

    logic [11:0]        ctrl;
    logic [11:0]        ctrl_sc;
    logic [2:0]         last;
    logic [2:0]         last_wr;
    logic [31:0]        htim;
    logic [31:0]        vtim;
    logic [31:0]        hvlen;
    logic [NUM_INT-1:0] pend;
    logic [NUM_INT-1:0] ien;
    logic [NUM_INT-1:0] pend_clr;
    logic               pend_to;
    logic               ien_to;
    logic [2:0]         vbank;
    logic [2:0]         vbank_inc;
    logic               acmp_q;
    logic [29:0]        vbar [NUM_VBAR];
    logic [29:0]        vbar_rd;

    bus_state_t         state;
    bus_state_t         state_nx;
    logic [7:0]         clut_cnt;
    logic [7:0]         cnt_nx;
    logic               ack_nx;
    logic               err_nx;
    logic               acc_nx;
    logic               to_set;
    logic               reg_wr;
    logic [31:0]        dat_nx;
    logic [31:0]        rd_data;

    logic [31:0]        wmask;
    logic [8:0]         offset;
    logic               wr_ctrl;
    logic               wr_stat;
    logic               wr_htim;
    logic               wr_vtim;
    logic               wr_hvlen;
    logic               wr_ien;

    assign wmask  = {{8{SEL_I[3]}}, {8{SEL_I[2]}}, {8{SEL_I[1]}}, {8{SEL_I[0]}}};
    assign offset = ADR_I[8:0];

    assign wr_ctrl  = reg_wr && (offset == 9'd0);
    assign wr_stat  = reg_wr && (offset == 9'd1);
    assign wr_htim  = reg_wr && (offset == 9'd2);
    assign wr_vtim  = reg_wr && (offset == 9'd3);
    assign wr_hvlen = reg_wr && (offset == 9'd4);
    assign wr_ien   = reg_wr && (offset == 9'd5);

    assign pend_clr = wr_stat ? (DAT_I[NUM_INT-1:0] & wmask[NUM_INT-1:0]) : '0;

    assign ctrl_o  = ctrl;
    assign htim_o  = htim;
    assign vtim_o  = vtim;
    assign hvlen_o = hvlen;

    // Self-clearing happens first; a CPU write then overrides only the lanes it touches.
    always_comb begin
        ctrl_sc = ctrl;
        if (vbs_done) begin
            ctrl_sc[1] = 1'b0;
        end
        if (acmp != acmp_q) begin
            ctrl_sc[2] = 1'b0;
        end
    end

    always_comb begin
        last_wr = (last & ~wmask[14:12]) | (DAT_I[14:12] & wmask[14:12]);
        if (last_wr > LAST_MAX) begin
            last_wr = LAST_MAX;
        end
    end

    // vbank can sit above a freshly lowered LAST; treat that as end of ring.
    assign vbank_inc = (vbank >= last) ? 3'd0 : vbank + 3'd1;

    always_comb begin
        vbar_cur = '0;
        vbar_nxt = '0;
        for (int i = 0; i < NUM_VBAR; i++) begin
            if (int'(vbank) == i) begin
                vbar_cur = vbar[i];
            end
            if (int'(vbank_inc) == i) begin
                vbar_nxt = vbar[i];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        vbar_rd = '0;
        for (int i = 0; i < NUM_VBAR; i++) begin
            if (int'(offset) == 8 + i) begin
                vbar_rd = vbar[i];
            end
        end
        case (offset)
            9'd0:    rd_data = {17'b0, last, ctrl};
            9'd1:    rd_data = 32'(pend) | {12'b0, acmp_q, vbank, pend_to, 15'b0};
            9'd2:    rd_data = htim;
            9'd3:    rd_data = vtim;
            9'd4:    rd_data = hvlen;
            9'd5:    rd_data = 32'(ien) | {16'b0, ien_to, 15'b0};
            default: begin
                if (int'(offset) >= 8 && int'(offset) < 8 + NUM_VBAR) begin
                    rd_data = {vbar_rd, 2'b00};
                end
            end
        endcase
    end

    always_ff @(posedge CLK_I or negedge nRESET) begin
        if (!nRESET) begin
            ctrl    <= '0;
            last    <= '0;
            htim    <= '0;
            vtim    <= '0;
            hvlen   <= '0;
            pend    <= '0;
            ien     <= '0;
            pend_to <= 1'b0;
            ien_to  <= 1'b0;
            vbank   <= '0;
            acmp_q  <= 1'b0;
            INTA_O  <= 1'b0;
            for (int i = 0; i < NUM_VBAR; i++) begin
                vbar[i] <= '0;
            end
        end else if (RST_I) begin
            ctrl    <= '0;
            last    <= '0;
            htim    <= '0;
            vtim    <= '0;
            hvlen   <= '0;
            pend    <= '0;
            ien     <= '0;
            pend_to <= 1'b0;
            ien_to  <= 1'b0;
            vbank   <= '0;
            acmp_q  <= 1'b0;
            INTA_O  <= 1'b0;
            for (int i = 0; i < NUM_VBAR; i++) begin
                vbar[i] <= '0;
            end
        end else begin
            acmp_q <= acmp;

            if (wr_ctrl) begin
                ctrl <= (ctrl_sc & ~wmask[11:0]) | (DAT_I[11:0] & wmask[11:0]);
                last <= last_wr;
            end else begin
                ctrl <= ctrl_sc;
            end

            if (wr_htim) begin
                htim <= (htim & ~wmask) | (DAT_I & wmask);
            end
            if (wr_vtim) begin
                vtim <= (vtim & ~wmask) | (DAT_I & wmask);
            end
            if (wr_hvlen) begin
                hvlen <= (hvlen & ~wmask) | (DAT_I & wmask);
            end
            if (wr_ien) begin
                ien <= (ien & ~wmask[NUM_INT-1:0]) | (DAT_I[NUM_INT-1:0] & wmask[NUM_INT-1:0]);
                if (wmask[15]) begin
                    ien_to <= DAT_I[15];
                end
            end

            // New events are OR-ed in after the clear so a same-cycle event survives.
            pend    <= (pend & ~pend_clr) | int_in;
            pend_to <= (pend_to & ~(wr_stat & wmask[15] & DAT_I[15])) | to_set;

            for (int i = 0; i < NUM_VBAR; i++) begin
                if (reg_wr && int'(offset) == 8 + i) begin
                    vbar[i] <= (vbar[i] & ~wmask[31:2]) | (DAT_I[31:2] & wmask[31:2]);
                end
            end

            if (vbs_done) begin
                vbank <= vbank_inc;
            end

            INTA_O <= |{pend & ien, pend_to & ien_to};
        end
    end

    always_ff @(posedge CLK_I or negedge nRESET) begin
        if (!nRESET) begin
            state    <= IDLE;
            clut_cnt <= '0;
            clut_acc <= 1'b0;
            ACK_O    <= 1'b0;
            ERR_O    <= 1'b0;
            DAT_O    <= '0;
        end else if (RST_I) begin
            state    <= IDLE;
            clut_cnt <= '0;
            clut_acc <= 1'b0;
            ACK_O    <= 1'b0;
            ERR_O    <= 1'b0;
            DAT_O    <= '0;
        end else begin
            state    <= state_nx;
            clut_cnt <= cnt_nx;
            clut_acc <= acc_nx;
            ACK_O    <= ack_nx;
            ERR_O    <= err_nx;
            DAT_O    <= dat_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = clut_cnt;
        acc_nx   = clut_acc;
        ack_nx   = 1'b0;
        err_nx   = 1'b0;
        dat_nx   = DAT_O;
        reg_wr   = 1'b0;
        to_set   = 1'b0;
        case (state)
            IDLE: begin
                if (CYC_I && STB_I) begin
                    if (ADR_I[9]) begin
                        if (SEL_I == 4'hF) begin
                            state_nx = CLUT_WAIT;
                            acc_nx   = 1'b1;
                            cnt_nx   = '0;
                        end else begin
                            state_nx = RESP;
                            err_nx   = 1'b1;
                            dat_nx   = '0;
                        end
                    end else begin
                        state_nx = RESP;
                        ack_nx   = 1'b1;
                        reg_wr   = WE_I;
                        if (!WE_I) begin
                            dat_nx = rd_data;
                        end
                    end
                end
            end
            CLUT_WAIT: begin
                if (!(CYC_I && STB_I)) begin
                    state_nx = IDLE;
                    acc_nx   = 1'b0;
                end else if (clut_ack) begin
                    state_nx = RESP;
                    acc_nx   = 1'b0;
                    ack_nx   = 1'b1;
                    dat_nx   = {8'h00, clut_q};
                end else if (clut_cnt == TO_LAST) begin
                    state_nx = RESP;
                    acc_nx   = 1'b0;
                    err_nx   = 1'b1;
                    to_set   = 1'b1;
                end else begin
                    cnt_nx = clut_cnt + 8'd1;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                acc_nx   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_vga_wb_regs_ng.sv
// ---------------------------------------------------------------------------
// tb_vga_wb_regs_ng
// Directed self-checking bench for vga_wb_regs_ng (NUM_VBAR=4, NUM_INT=6,
// CLUT_TO=15). A vector table covers register reads/writes and byte lanes;
// hand-written sequences cover bank rotation, interrupts, CLUT handshake,
// timeout, abort and reset during a CLUT wait.
// ---------------------------------------------------------------------------
module tb_vga_wb_regs_ng;

    localparam int NV = 4;
    localparam int NI = 6;
    localparam int TO = 15;

    logic          CLK_I    = 1'b0;
    logic          nRESET   = 1'b0;
    logic          RST_I    = 1'b0;
    logic [9:0]    ADR_I    = '0;
    logic [31:0]   DAT_I    = '0;
    logic [31:0]   DAT_O;
    logic [3:0]    SEL_I    = '0;
    logic          WE_I     = 1'b0;
    logic          STB_I    = 1'b0;
    logic          CYC_I    = 1'b0;
    logic          ACK_O;
    logic          ERR_O;
    logic          INTA_O;
    logic [NI-1:0] int_in   = '0;
    logic          vbs_done = 1'b0;
    logic          acmp     = 1'b0;
    logic [11:0]   ctrl_o;
    logic [31:0]   htim_o;
    logic [31:0]   vtim_o;
    logic [31:0]   hvlen_o;
    logic [29:0]   vbar_cur;
    logic [29:0]   vbar_nxt;
    logic          clut_acc;
    logic          clut_ack = 1'b0;
    logic [23:0]   clut_q   = '0;

    int checks   = 0;
    int failures = 0;

    vga_wb_regs_ng #(.NUM_VBAR(NV), .NUM_INT(NI), .CLUT_TO(TO)) dut (
        .CLK_I    (CLK_I),
        .nRESET   (nRESET),
        .RST_I    (RST_I),
        .ADR_I    (ADR_I),
        .DAT_I    (DAT_I),
        .DAT_O    (DAT_O),
        .SEL_I    (SEL_I),
        .WE_I     (WE_I),
        .STB_I    (STB_I),
        .CYC_I    (CYC_I),
        .ACK_O    (ACK_O),
        .ERR_O    (ERR_O),
        .INTA_O   (INTA_O),
        .int_in   (int_in),
        .vbs_done (vbs_done),
        .acmp     (acmp),
        .ctrl_o   (ctrl_o),
        .htim_o   (htim_o),
        .vtim_o   (vtim_o),
        .hvlen_o  (hvlen_o),
        .vbar_cur (vbar_cur),
        .vbar_nxt (vbar_nxt),
        .clut_acc (clut_acc),
        .clut_ack (clut_ack),
        .clut_q   (clut_q)
    );

    always #5 CLK_I = ~CLK_I;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        we;
        logic [8:0]  off;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [8:0] off, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [31:0] exp, input string name);
        vec_t v;
        v.we   = we;
        v.off  = off;
        v.dat  = dat;
        v.sel  = sel;
        v.exp  = exp;
        v.name = name;
        tbl.push_back(v);
    endtask

    // One Wishbone cycle; ipulse is driven on int_in during the strobe cycle only.
    task automatic wb(input logic we, input logic [9:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input logic [NI-1:0] ipulse,
                      output logic [31:0] rd, output logic ga, output logic ge, output int lat);
        @(posedge CLK_I);
        #1;
        CYC_I  = 1'b1;
        STB_I  = 1'b1;
        WE_I   = we;
        ADR_I  = adr;
        DAT_I  = dat;
        SEL_I  = sel;
        int_in = ipulse;
        ga     = 1'b0;
        ge     = 1'b0;
        lat    = 0;
        rd     = '0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge CLK_I);
            #1;
            int_in = '0;
            if (ACK_O || ERR_O) begin
                ga  = ACK_O;
                ge  = ERR_O;
                lat = n;
                rd  = DAT_O;
                break;
            end
        end
        CYC_I = 1'b0;
        STB_I = 1'b0;
        WE_I  = 1'b0;
    endtask

    task automatic reg_write(input logic [8:0] off, input logic [31:0] dat, input logic [3:0] sel,
                             input logic [NI-1:0] ipulse, input string name);
        logic [31:0] rd;
        logic        ga;
        logic        ge;
        int          lat;
        wb(1'b1, {1'b0, off}, dat, sel, ipulse, rd, ga, ge, lat);
        chk({name, "_ack"}, {ge, ga, 30'(lat)}, {1'b0, 1'b1, 30'd1});
    endtask

    task automatic reg_read(input logic [8:0] off, input logic [31:0] exp, input string name);
        logic [31:0] rd;
        logic        ga;
        logic        ge;
        int          lat;
        wb(1'b0, {1'b0, off}, 32'h0, 4'hF, '0, rd, ga, ge, lat);
        chk({name, "_ack"}, {ge, ga, 30'(lat)}, {1'b0, 1'b1, 30'd1});
        chk(name, rd, exp);
    endtask

    task automatic pulse_vbs();
        @(posedge CLK_I);
        #1;
        vbs_done = 1'b1;
        @(posedge CLK_I);
        #1;
        vbs_done = 1'b0;
    endtask

    // CLUT read; ack_dly<0 withholds clut_ack, abort_at>0 drops CYC/STB after that cycle.
    task automatic clut_rd(input logic [3:0] sel, input int ack_dly, input int abort_at,
                           output logic ga, output logic ge, output int lat,
                           output logic [31:0] rd, output logic acc_seen);
        int limit;
        limit = (abort_at > 0) ? abort_at + 4 : 40;
        @(posedge CLK_I);
        #1;
        CYC_I    = 1'b1;
        STB_I    = 1'b1;
        WE_I     = 1'b0;
        ADR_I    = 10'h205;
        SEL_I    = sel;
        ga       = 1'b0;
        ge       = 1'b0;
        lat      = 0;
        rd       = '0;
        acc_seen = 1'b0;
        for (int n = 1; n <= limit; n++) begin
            @(posedge CLK_I);
            #1;
            if (clut_acc) acc_seen = 1'b1;
            if (ACK_O || ERR_O) begin
                ga  = ACK_O;
                ge  = ERR_O;
                lat = n;
                rd  = DAT_O;
                break;
            end
            clut_ack = (ack_dly >= 0) && (n == 1 + ack_dly);
            if (n == abort_at) begin
                CYC_I = 1'b0;
                STB_I = 1'b0;
            end
        end
        clut_ack = 1'b0;
        CYC_I    = 1'b0;
        STB_I    = 1'b0;
    endtask

    logic [31:0] rd;
    logic        ga;
    logic        ge;
    logic        acc_seen;
    logic        seen;
    int          lat;

    initial begin
        repeat (2) @(posedge CLK_I);
        #3;
        nRESET = 1'b1;
        @(posedge CLK_I);
        #1;
        chk("rst_ACK_O", 32'(ACK_O), 32'd0);
        chk("rst_ERR_O", 32'(ERR_O), 32'd0);
        chk("rst_INTA_O", 32'(INTA_O), 32'd0);
        chk("rst_clut_acc", 32'(clut_acc), 32'd0);
        chk("rst_vbar_cur", 32'(vbar_cur), 32'd0);

        // register map vectors
        add(1'b0, 9'd0,  32'h0,         4'hF,    32'h0,         "rd_ctrl_rst");
        add(1'b0, 9'd1,  32'h0,         4'hF,    32'h0,         "rd_stat_rst");
        add(1'b0, 9'd2,  32'h0,         4'hF,    32'h0,         "rd_htim_rst");
        add(1'b0, 9'd3,  32'h0,         4'hF,    32'h0,         "rd_vtim_rst");
        add(1'b0, 9'd4,  32'h0,         4'hF,    32'h0,         "rd_hvlen_rst");
        add(1'b0, 9'd5,  32'h0,         4'hF,    32'h0,         "rd_ien_rst");
        add(1'b0, 9'd8,  32'h0,         4'hF,    32'h0,         "rd_vbar0_rst");
        add(1'b0, 9'd9,  32'h0,         4'hF,    32'h0,         "rd_vbar1_rst");
        add(1'b1, 9'd2,  32'h1234_5678, 4'hF,    32'h0,         "wr_htim");
        add(1'b0, 9'd2,  32'h0,         4'hF,    32'h1234_5678, "rd_htim");
        add(1'b1, 9'd2,  32'hAABB_CCDD, 4'b0100, 32'h0,         "wr_htim_b2");
        add(1'b0, 9'd2,  32'h0,         4'hF,    32'h12BB_5678, "rd_htim_b2");
        add(1'b1, 9'd8,  32'hFFFF_FFFF, 4'hF,    32'h0,         "wr_vbar0_ones");
        add(1'b0, 9'd8,  32'h0,         4'hF,    32'hFFFF_FFFC, "rd_vbar0_ones");
        add(1'b1, 9'd8,  32'h1000_0003, 4'b0011, 32'h0,         "wr_vbar0_lo");
        add(1'b0, 9'd8,  32'h0,         4'hF,    32'hFFFF_0000, "rd_vbar0_lo");
        add(1'b1, 9'd0,  32'h0000_7FFF, 4'hF,    32'h0,         "wr_ctrl_clamp");
        add(1'b0, 9'd0,  32'h0,         4'hF,    32'h0000_3FFF, "rd_ctrl_clamp");
        add(1'b1, 9'd5,  32'hFFFF_FFFF, 4'hF,    32'h0,         "wr_ien_all");
        add(1'b0, 9'd5,  32'h0,         4'hF,    32'h0000_803F, "rd_ien_all");
        add(1'b1, 9'd6,  32'hFFFF_FFFF, 4'hF,    32'h0,         "wr_unmapped6");
        add(1'b0, 9'd6,  32'h0,         4'hF,    32'h0,         "rd_unmapped6");
        add(1'b0, 9'd12, 32'h0,         4'hF,    32'h0,         "rd_unmapped12");
        add(1'b1, 9'd3,  32'hFFFF_FFFF, 4'b1000, 32'h0,         "wr_vtim_b3");
        add(1'b0, 9'd3,  32'h0,         4'hF,    32'hFF00_0000, "rd_vtim_b3");
        add(1'b1, 9'd4,  32'h0000_ABCD, 4'b0001, 32'h0,         "wr_hvlen_b0");
        add(1'b0, 9'd4,  32'h0,         4'hF,    32'h0000_00CD, "rd_hvlen_b0");
        add(1'b1, 9'd0,  32'h0,         4'hF,    32'h0,         "wr_ctrl_zero");
        add(1'b1, 9'd5,  32'h0,         4'hF,    32'h0,         "wr_ien_zero");
        add(1'b0, 9'd1,  32'h0,         4'hF,    32'h0,         "rd_stat_quiet");

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].we) reg_write(tbl[i].off, tbl[i].dat, tbl[i].sel, '0, tbl[i].name);
            else           reg_read(tbl[i].off, tbl[i].exp, tbl[i].name);
        end
        chk("htim_o", htim_o, 32'h12BB_5678);
        chk("vtim_o", vtim_o, 32'hFF00_0000);
        chk("hvlen_o", hvlen_o, 32'h0000_00CD);

        // bank ring: LAST=2
        reg_write(9'd0,  32'h0000_2000, 4'hF, '0, "wr_last2");
        reg_write(9'd8,  32'h0000_0100, 4'hF, '0, "wr_vbar0");
        reg_write(9'd9,  32'h0000_0200, 4'hF, '0, "wr_vbar1");
        reg_write(9'd10, 32'h0000_0300, 4'hF, '0, "wr_vbar2");
        chk("bank0_cur", 32'(vbar_cur), 32'h40);
        chk("bank0_nxt", 32'(vbar_nxt), 32'h80);
        pulse_vbs();
        chk("bank1_cur", 32'(vbar_cur), 32'h80);
        chk("bank1_nxt", 32'(vbar_nxt), 32'hC0);
        pulse_vbs();
        chk("bank2_cur", 32'(vbar_cur), 32'hC0);
        chk("bank2_nxt", 32'(vbar_nxt), 32'h40);
        reg_read(9'd1, 32'h0002_0000, "rd_stat_vbank2");
        pulse_vbs();
        chk("bank_wrap_cur", 32'(vbar_cur), 32'h40);
        chk("bank_wrap_nxt", 32'(vbar_nxt), 32'h80);
        pulse_vbs();
        pulse_vbs();
        reg_write(9'd0, 32'h0, 4'hF, '0, "wr_last0");
        chk("lastlow_cur", 32'(vbar_cur), 32'hC0);
        chk("lastlow_nxt", 32'(vbar_nxt), 32'h40);
        pulse_vbs();
        chk("lastlow_wrap_cur", 32'(vbar_cur), 32'h40);
        reg_read(9'd1, 32'h0, "rd_stat_vbank0");

        // interrupts
        reg_write(9'd5, 32'h1, 4'hF, '0, "wr_ien0");
        @(posedge CLK_I);
        #1;
        int_in = 6'h01;
        @(posedge CLK_I);
        #1;
        int_in = '0;
        chk("inta_lag", 32'(INTA_O), 32'd0);
        @(posedge CLK_I);
        #1;
        chk("inta_set", 32'(INTA_O), 32'd1);
        reg_read(9'd1, 32'h1, "rd_stat_pend0");
        reg_write(9'd1, 32'h1, 4'hF, 6'h01, "w1c_with_event");
        reg_read(9'd1, 32'h1, "rd_stat_set_wins");
        chk("inta_still", 32'(INTA_O), 32'd1);
        reg_write(9'd1, 32'h1, 4'hF, '0, "w1c_plain");
        chk("inta_drop_lag", 32'(INTA_O), 32'd1);
        @(posedge CLK_I);
        #1;
        chk("inta_dropped", 32'(INTA_O), 32'd0);
        reg_read(9'd1, 32'h0, "rd_stat_cleared");
        @(posedge CLK_I);
        #1;
        int_in = 6'h02;
        @(posedge CLK_I);
        #1;
        int_in = '0;
        repeat (2) @(posedge CLK_I);
        #1;
        chk("inta_masked", 32'(INTA_O), 32'd0);
        reg_read(9'd1, 32'h2, "rd_stat_pend1");
        reg_write(9'd1, 32'h2, 4'hF, '0, "w1c_pend1");
        reg_write(9'd5, 32'h0, 4'hF, '0, "wr_ien_off");

        // acmp sampling and self-clearing control bits
        acmp = 1'b1;
        repeat (2) @(posedge CLK_I);
        reg_read(9'd1, 32'h0008_0000, "rd_stat_acmp");
        reg_write(9'd0, 32'h4, 4'hF, '0, "wr_cbsw");
        reg_read(9'd0, 32'h4, "rd_cbsw_held");
        acmp = 1'b0;
        repeat (2) @(posedge CLK_I);
        reg_read(9'd0, 32'h0, "rd_cbsw_cleared");
        reg_write(9'd0, 32'h2, 4'hF, '0, "wr_vbsw");
        reg_read(9'd0, 32'h2, "rd_vbsw_held");
        pulse_vbs();
        reg_read(9'd0, 32'h0, "rd_vbsw_cleared");

        // CLUT accesses
        clut_q = 24'hAB_CDEF;
        clut_rd(4'hF, 3, 0, ga, ge, lat, rd, acc_seen);
        chk("clut_ack_resp", {ge, ga, 30'(lat)}, {1'b0, 1'b1, 30'd5});
        chk("clut_ack_data", rd, 32'h00AB_CDEF);
        chk("clut_acc_seen", 32'(acc_seen), 32'd1);
        chk("clut_acc_off", 32'(clut_acc), 32'd0);

        clut_rd(4'hF, -1, 0, ga, ge, lat, rd, acc_seen);
        chk("clut_timeout", {ge, ga, 30'(lat)}, {1'b1, 1'b0, 30'(TO + 1)});
        chk("clut_to_acc_off", 32'(clut_acc), 32'd0);
        reg_read(9'd1, 32'h0000_8000, "rd_stat_to");
        chk("inta_to_masked", 32'(INTA_O), 32'd0);
        reg_write(9'd5, 32'h8000, 4'b0010, '0, "wr_ien_to");
        @(posedge CLK_I);
        #1;
        chk("inta_to", 32'(INTA_O), 32'd1);
        reg_write(9'd1, 32'h8000, 4'hF, '0, "w1c_to");
        reg_read(9'd1, 32'h0, "rd_stat_to_clr");
        reg_write(9'd5, 32'h0, 4'hF, '0, "wr_ien_off2");

        clut_q = 24'h13_5791;
        clut_rd(4'hF, TO - 1, 0, ga, ge, lat, rd, acc_seen);
        chk("clut_ack_at_to", {ge, ga, 30'(lat)}, {1'b0, 1'b1, 30'(TO + 1)});
        chk("clut_ack_at_to_data", rd, 32'h0013_5791);
        reg_read(9'd1, 32'h0, "rd_stat_no_to");

        clut_rd(4'h1, -1, 0, ga, ge, lat, rd, acc_seen);
        chk("clut_sel_err", {ge, ga, 30'(lat)}, {1'b1, 1'b0, 30'd1});
        chk("clut_sel_err_data", rd, 32'h0);
        chk("clut_sel_no_acc", 32'(acc_seen), 32'd0);

        clut_rd(4'hF, -1, 3, ga, ge, lat, rd, acc_seen);
        chk("clut_abort_noresp", {30'd0, ge, ga}, 32'd0);
        chk("clut_abort_acc_seen", 32'(acc_seen), 32'd1);
        chk("clut_abort_acc_off", 32'(clut_acc), 32'd0);
        clut_q = 24'h24_6802;
        clut_rd(4'hF, 2, 0, ga, ge, lat, rd, acc_seen);
        chk("clut_after_abort", {ge, ga, 30'(lat)}, {1'b0, 1'b1, 30'd4});
        chk("clut_after_abort_data", rd, 32'h0024_6802);

        // nRESET in the middle of a CLUT wait
        @(posedge CLK_I);
        #1;
        CYC_I = 1'b1;
        STB_I = 1'b1;
        WE_I  = 1'b0;
        ADR_I = 10'h205;
        SEL_I = 4'hF;
        repeat (3) @(posedge CLK_I);
        #1;
        chk("mid_wait_acc", 32'(clut_acc), 32'd1);
        nRESET = 1'b0;
        #2;
        chk("rst_wait_acc", 32'(clut_acc), 32'd0);
        CYC_I = 1'b0;
        STB_I = 1'b0;
        seen  = 1'b0;
        repeat (2) begin
            @(posedge CLK_I);
            #1;
            if (ACK_O || ERR_O) seen = 1'b1;
        end
        nRESET = 1'b1;
        repeat (3) begin
            @(posedge CLK_I);
            #1;
            if (ACK_O || ERR_O) seen = 1'b1;
        end
        chk("rst_wait_noresp", 32'(seen), 32'd0);
        reg_read(9'd2, 32'h0, "rd_htim_after_rst");
        chk("vbar_cur_after_rst", 32'(vbar_cur), 32'd0);
        clut_q = 24'hFE_DCBA;
        clut_rd(4'hF, 0, 0, ga, ge, lat, rd, acc_seen);
        chk("clut_after_rst", {ge, ga, 30'(lat)}, {1'b0, 1'b1, 30'd2});
        chk("clut_after_rst_data", rd, 32'h00FE_DCBA);

        // synchronous reset
        reg_write(9'd2, 32'h55, 4'hF, '0, "wr_htim_55");
        chk("htim_o_55", htim_o, 32'h55);
        @(posedge CLK_I);
        #1;
        RST_I = 1'b1;
        @(posedge CLK_I);
        #1;
        RST_I = 1'b0;
        chk("htim_o_sync_rst", htim_o, 32'h0);
        reg_read(9'd2, 32'h0, "rd_htim_sync_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
